// File: rtl/data_mem_responder.sv
// Memory-stage data-memory responder: 16/32-bit reads and writes over a 16-bit array,
// one beat per cycle, with completion pulse, busy flag and out-of-range fault pulse.
module data_mem_responder #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic        clk,
  input  logic        i_reset,
  input  logic        i_memRead,
  input  logic        i_memWrite,
  input  logic        i_en32,
  input  logic [31:0] i_address,
  input  logic [31:0] i_data_in,
  output logic [31:0] o_data_out,
  output logic        o_valid,
  output logic        o_busy,
  output logic        o_fault
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BEAT0 = 3'd1,
    S_BEAT1 = 3'd2,
    S_RESP  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic                en32_q;
  logic                write_q;

  logic [15:0]         mem_q [DEPTH];

  logic                req_c;
  logic                fault_c;
  logic                mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [15:0]         mem_wdata_d;
  logic [15:0]         mem_rdata_c;

  assign o_busy = (state_q != S_IDLE);
  assign req_c  = i_memRead | i_memWrite;

  // Reject out-of-range, last-word 32-bit (no wrap) and ambiguous read+write requests.
  always_comb begin
    fault_c = 1'b0;
    if ((i_address >> ADDR_W) != 32'd0) begin
      fault_c = 1'b1;
    end
    if (i_en32 && (i_address[ADDR_W-1:0] == ADDR_W'(DEPTH - 1))) begin
      fault_c = 1'b1;
    end
    if (i_memRead && i_memWrite) begin
      fault_c = 1'b1;
    end
  end

  // Beat address/data select; a reset edge suppresses the pending beat write.
  always_comb begin
    mem_addr_d  = addr_q;
    mem_wdata_d = wdata_q[15:0];
    mem_we_d    = 1'b0;
    if (state_q == S_BEAT1) begin
      mem_addr_d = addr_q + ADDR_W'(1);
    end
    if ((state_q == S_BEAT0) && en32_q) begin
      mem_wdata_d = wdata_q[31:16];
    end
    if (write_q && !i_reset && ((state_q == S_BEAT0) || (state_q == S_BEAT1))) begin
      mem_we_d = 1'b1;
    end
  end

  assign mem_rdata_c = mem_q[mem_addr_d];

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_d) begin
      mem_q[mem_addr_d] <= mem_wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      en32_q     <= 1'b0;
      write_q    <= 1'b0;
      o_data_out <= 32'd0;
      o_valid    <= 1'b0;
      o_fault    <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      o_fault <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_c) begin
            addr_q  <= i_address[ADDR_W-1:0];
            wdata_q <= i_data_in;
            en32_q  <= i_en32;
            write_q <= i_memWrite;
            state_q <= fault_c ? S_FAULT : S_BEAT0;
          end
        end
        S_BEAT0: begin
          if (!write_q) begin
            if (en32_q) begin
              o_data_out[31:16] <= mem_rdata_c;
            end else begin
              o_data_out <= {16'h0000, mem_rdata_c};
            end
          end
          state_q <= en32_q ? S_BEAT1 : S_RESP;
        end
        S_BEAT1: begin
          if (!write_q) begin
            o_data_out[15:0] <= mem_rdata_c;
          end
          state_q <= S_RESP;
        end
        S_RESP: begin
          o_valid <= 1'b1;
          state_q <= S_IDLE;
        end
        S_FAULT: begin
          o_fault <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: directed scenarios plus random traffic
// checked against an array-based model of the word-addressed memory.
module tb_data_mem_responder;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_memRead;
  logic        i_memWrite;
  logic        i_en32;
  logic [31:0] i_address;
  logic [31:0] i_data_in;
  logic [31:0] o_data_out;
  logic        o_valid;
  logic        o_busy;
  logic        o_fault;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .i_reset    (i_reset),
    .i_memRead  (i_memRead),
    .i_memWrite (i_memWrite),
    .i_en32     (i_en32),
    .i_address  (i_address),
    .i_data_in  (i_data_in),
    .o_data_out (o_data_out),
    .o_valid    (o_valid),
    .o_busy     (o_busy),
    .o_fault    (o_fault)
  );

  typedef struct {
    bit          fault;
    logic [31:0] data;
    longint      t_acc;
    int          lat;
  } exp_t;

  exp_t        sbq[$];
  logic [15:0] m [DEPTH];
  logic [31:0] last_rd;
  int          checks;
  int          failures;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every completion or fault pulse consumes one expected response.
  always @(negedge clk) begin
    if (!i_reset && (o_valid || o_fault)) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse valid=%b fault=%b at t=%0t", o_valid, o_fault, $time);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("fault_flag", 32'(o_fault), 32'(e.fault));
        chk("valid_flag", 32'(o_valid), 32'(!e.fault));
        chk("data_out", o_data_out, e.data);
        chk("latency", 32'($time - e.t_acc), 32'(e.lat * 10 + 5));
      end
    end
  end

  function automatic bit is_fault(input bit rd, input bit wr, input bit e32, input logic [31:0] a);
    return (a >= 32'(DEPTH)) || (e32 && (a == 32'(DEPTH - 1))) || (rd && wr);
  endfunction

  // Builds the expected response for an op accepted now and applies it to the model.
  task automatic model_op(input bit rd, input bit wr, input bit e32,
                          input logic [31:0] a, input logic [31:0] d, input longint t);
    exp_t e;
    e.t_acc = t;
    e.fault = is_fault(rd, wr, e32, a);
    if (e.fault) begin
      e.lat  = 1;
      e.data = last_rd;
    end else begin
      e.lat = e32 ? 3 : 2;
      if (wr) begin
        if (e32) begin
          m[a[ADDR_W-1:0]]     = d[31:16];
          m[a[ADDR_W-1:0] + 1] = d[15:0];
        end else begin
          m[a[ADDR_W-1:0]] = d[15:0];
        end
      end else begin
        last_rd = e32 ? {m[a[ADDR_W-1:0]], m[a[ADDR_W-1:0] + 1]} : {16'h0000, m[a[ADDR_W-1:0]]};
      end
      e.data = last_rd;
    end
    sbq.push_back(e);
  endtask

  task automatic issue(input bit rd, input bit wr, input bit e32,
                       input logic [31:0] a, input logic [31:0] d, input bit track);
    int g;
    @(negedge clk);
    i_memRead  = rd;
    i_memWrite = wr;
    i_en32     = e32;
    i_address  = a;
    i_data_in  = d;
    g = 0;
    while (o_busy && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (g >= 20) begin
      checks++;
      failures++;
      $display("FAIL busy_timeout addr=%h at t=%0t", a, $time);
    end
    @(posedge clk);
    if (track) model_op(rd, wr, e32, a, d, $time);
    @(negedge clk);
    i_memRead  = 1'b0;
    i_memWrite = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((sbq.size() != 0 || o_busy) && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout pending=%0d at t=%0t", sbq.size(), $time);
    end
    @(negedge clk);
  endtask

  initial begin
    int     acc;
    longint prev_t;
    checks     = 0;
    failures   = 0;
    last_rd    = 32'd0;
    i_reset    = 1'b1;
    i_memRead  = 1'b0;
    i_memWrite = 1'b0;
    i_en32     = 1'b0;
    i_address  = 32'd0;
    i_data_in  = 32'd0;
    repeat (3) @(negedge clk);
    i_reset = 1'b0;
    @(negedge clk);
    chk("reset_data_out", o_data_out, 32'd0);
    chk("reset_valid", 32'(o_valid), 32'd0);
    chk("reset_fault", 32'(o_fault), 32'd0);
    chk("reset_busy", 32'(o_busy), 32'd0);

    // Give every word the bench touches a known value.
    for (int i = 0; i <= 'h40; i++) issue(1'b0, 1'b1, 1'b0, 32'(i), $urandom, 1'b1);
    issue(1'b0, 1'b1, 1'b0, 32'hFFE, 32'h0000_C0DE, 1'b1);
    issue(1'b0, 1'b1, 1'b0, 32'hFFF, 32'h0000_F00D, 1'b1);

    issue(1'b0, 1'b1, 1'b0, 32'h010, 32'h0000_BEEF, 1'b1);
    issue(1'b1, 1'b0, 1'b0, 32'h010, 32'h0, 1'b1);
    issue(1'b0, 1'b1, 1'b1, 32'h020, 32'h1234_5678, 1'b1);
    issue(1'b1, 1'b0, 1'b0, 32'h020, 32'h0, 1'b1);
    issue(1'b1, 1'b0, 1'b0, 32'h021, 32'h0, 1'b1);
    issue(1'b1, 1'b0, 1'b1, 32'h020, 32'h0, 1'b1);

    issue(1'b0, 1'b1, 1'b0, 32'h0000_1000, 32'h0000_1111, 1'b1);
    issue(1'b0, 1'b1, 1'b1, 32'h0000_0FFF, 32'h2222_3333, 1'b1);
    issue(1'b1, 1'b1, 1'b0, 32'h0000_0FFF, 32'h0000_4444, 1'b1);
    issue(1'b1, 1'b0, 1'b0, 32'h0000_0FFF, 32'h0, 1'b1);
    drain();

    // Request held continuously: accepts every third cycle; busy-time address changes ignored.
    i_memRead  = 1'b1;
    i_memWrite = 1'b0;
    i_en32     = 1'b0;
    acc        = 0;
    prev_t     = 0;
    for (int k = 0; k < 30; k++) begin
      if (!o_busy) begin
        i_address = 32'h020;
        if (acc > 0) chk("b2b_spacing", 32'($time + 5 - prev_t), 32'd30);
        prev_t = $time + 5;
        model_op(1'b1, 1'b0, 1'b0, 32'h020, 32'h0, prev_t);
        acc++;
      end else begin
        i_address = 32'h021;
      end
      @(negedge clk);
    end
    i_memRead = 1'b0;
    chk("b2b_accepts", 32'(acc), 32'd10);
    drain();

    issue(1'b1, 1'b0, 1'b1, 32'h020, 32'h0, 1'b1);
    issue(1'b0, 1'b1, 1'b0, 32'h025, 32'h0000_9999, 1'b1);
    drain();

    // Reset lands on the BEAT1 edge of a 32-bit write.
    issue(1'b0, 1'b1, 1'b1, 32'h030, 32'hAAAA_5555, 1'b0);
    @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    chk("midrst_data_out", o_data_out, 32'd0);
    chk("midrst_valid", 32'(o_valid), 32'd0);
    chk("midrst_fault", 32'(o_fault), 32'd0);
    chk("midrst_busy", 32'(o_busy), 32'd0);
    i_reset = 1'b0;
    m['h030] = 16'hAAAA;
    last_rd  = 32'd0;
    issue(1'b1, 1'b0, 1'b0, 32'h030, 32'h0, 1'b1);
    issue(1'b1, 1'b0, 1'b0, 32'h031, 32'h0, 1'b1);

    for (int n = 0; n < 150; n++) begin
      int unsigned sel;
      int unsigned op;
      logic [31:0] a;
      sel = $urandom_range(0, 9);
      op  = $urandom_range(0, 9);
      if (sel <= 6)      a = 32'($urandom_range(0, 'h3F));
      else if (sel == 7) a = 32'($urandom_range('hFFE, 'hFFF));
      else if (sel == 8) a = 32'h0000_1000 | 32'($urandom_range(0, 'hFFF));
      else               a = $urandom | 32'h8000_0000;
      issue(op <= 4 || op == 9, op >= 5, 1'($urandom), a, $urandom, 1'b1);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the memory-stage data-memory request interface.
- Accepts read/write requests (16- or 32-bit) from the memory stage and services them over a 16-bit-wide internal array, one beat per cycle.
- Returns read data with a completion pulse, drives a busy/stall flag back to the pipeline, and flags out-of-range accesses to the exception logic (EPC path).

Parameters:
ADDR_W, 12, word-address width; array depth DEPTH = 2^ADDR_W 16-bit words.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_memRead  input  1  read request.
- i_memWrite  input  1  write request.
- i_en32  input  1  1 = 32-bit access (two words); 0 = 16-bit access.
- i_address  input  32  word address.
- i_data_in  input  32  write data; 16-bit writes use [15:0].
- o_data_out  output  32  read data, registered.
- o_valid  output  1  one-cycle completion pulse (read or write).
- o_busy  output  1  request not accepted this cycle; requester holds its request.
- o_fault  output  1  one-cycle pulse: request rejected, no memory access.

Behaviour:
- Reset: state=IDLE; o_data_out=0, o_valid=0, o_fault=0, o_busy=0; latched request cleared. Array contents are NOT cleared.
- Reset mid-operation aborts at the next edge. A beat already written stays written; the pending BEAT1 write is dropped; no o_valid or o_fault is issued.
- Accept: in IDLE with (i_memRead | i_memWrite) at a rising edge.
  - Latch address, data, en32 and op.
  - o_busy is combinational: 0 only in IDLE.
- Fault check at accept:
  - Fault if i_address[31:ADDR_W] != 0.
  - Fault if i_en32 and i_address[ADDR_W-1:0] == DEPTH-1. There is no wrap-around.
  - Fault if i_memRead and i_memWrite are both asserted.
  - Any fault -> FAULT state.
- Word order for 32-bit accesses: mem[A] holds bits [31:16]; mem[A+1] holds bits [15:0].
- FSM:
  - IDLE -> BEAT0 or FAULT on accept; otherwise stays in IDLE.
  - BEAT0 for a 16-bit access: write mem[A] <= data[15:0], or read o_data_out <= {16'b0, mem[A]}. Next state RESP.
  - BEAT0 for a 32-bit access: write mem[A] <= data[31:16], or read o_data_out[31:16] <= mem[A]. Next state BEAT1.
  - BEAT1: write mem[A+1] <= data[15:0], or read o_data_out[15:0] <= mem[A+1]. Next state RESP.
  - RESP: o_valid=1 for exactly one cycle, then IDLE.
  - FAULT: o_fault=1 for exactly one cycle, then IDLE. o_data_out is unchanged.
- Latency (accept edge = edge 0):
  - 16-bit: o_valid high in the cycle after edge 2.
  - 32-bit: o_valid high in the cycle after edge 3.
  - Fault: o_fault high in the cycle after edge 1.
  - Next accept is possible at the edge that leaves RESP or FAULT.
- o_data_out holds the last read result. Writes and faults do not modify it.
  - During a 32-bit read, [31:16] updates one cycle before [15:0]. Consumers sample only when o_valid=1.
- Request inputs are ignored while o_busy=1. They are sampled only at the accept edge, so later changes do not affect the operation in flight.
- o_valid and o_fault are never high in the same cycle.

Test Plan:
- 16-bit write A=0x010, data=0x0000BEEF, then 16-bit read A=0x010 -> o_valid after 2 edges per op; o_data_out=0x0000BEEF; o_busy=1 for 2 cycles per op.
- 32-bit write A=0x020, data=0x12345678; 16-bit reads of A=0x020 and A=0x021 -> 0x00001234 and 0x00005678; a 32-bit read of A=0x020 -> 0x12345678 with o_valid 3 cycles after accept.
- Faults: A=0x00001000; 32-bit A=0x0FFF; read and write together -> each gives o_fault=1 for one cycle, o_valid=0, and memory at 0x0FFF is unchanged (checked by a 16-bit read).
- Back-to-back: hold i_memRead=1 continuously on A=0x020, 16-bit -> exactly one accept per 3 cycles; a changed i_address while busy is not used.
- Reset in BEAT1 of a 32-bit write to A=0x030, data=0xAAAA5555 -> next cycle IDLE with all outputs 0; reads give mem[0x030]=0xAAAA and mem[0x031] unchanged from before.
- A write following a read leaves o_data_out holding the read value (0x12345678) through the write's RESP cycle.
